// File: rtl/reservation_station_if.sv
// Handshake bundle between rename/regread, the completion bus, the ALU and the reservation station.
// Latency: none; signal grouping only.
// Backpressure: in_ready throttles the dispatch side; issue_ready throttles the station.
interface reservation_station_if #(
  parameter int DEPTH  = 4,
  parameter int OP_W   = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 64
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [TAG_W-1:0]  in_dest_tag;
  logic              src1_valid;
  logic [DATA_W-1:0] src1_data;
  logic [TAG_W-1:0]  src1_tag;
  logic              src2_valid;
  logic [DATA_W-1:0] src2_data;
  logic [TAG_W-1:0]  src2_tag;
  logic              complete_en;
  logic [TAG_W-1:0]  complete_tag;
  logic [DATA_W-1:0] complete_data;
  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic [TAG_W-1:0]  issue_dest_tag;
  logic [OCC_W-1:0]  occupancy;

  // Dispatch / completion / execution side.
  modport master (
    output in_valid, in_op, in_dest_tag,
           src1_valid, src1_data, src1_tag,
           src2_valid, src2_data, src2_tag,
           complete_en, complete_tag, complete_data,
           issue_ready,
    input  in_ready, issue_valid, issue_op, issue_a, issue_b, issue_dest_tag, occupancy
  );

  // Reservation station side.
  modport slave (
    input  in_valid, in_op, in_dest_tag,
           src1_valid, src1_data, src1_tag,
           src2_valid, src2_data, src2_tag,
           complete_en, complete_tag, complete_data,
           issue_ready,
    output in_ready, issue_valid, issue_op, issue_a, issue_b, issue_dest_tag, occupancy
  );
endinterface

// File: rtl/reservation_station.sv
// Age-ordered issue queue: captures renamed ops, wakes pending operands from the completion bus, issues oldest ready.
// Latency: ready-at-accept op issues next cycle; operand woken in cycle N is issuable in N+1.
// Backpressure: in_ready = not full (no same-cycle credit from issue); issue held until issue_ready.
module reservation_station #(
  parameter int DEPTH  = 4,
  parameter int OP_W   = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 64
) (
  input logic                 clock,
  input logic                 reset_n,
  input logic                 flash,
  reservation_station_if.slave rs
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest_tag;
    logic              rdy1;
    logic [DATA_W-1:0] data1;
    logic [TAG_W-1:0]  tag1;
    logic              rdy2;
    logic [DATA_W-1:0] data2;
    logic [TAG_W-1:0]  tag2;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  entry_t            woke  [DEPTH];
  entry_t            new_ent;
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;
  logic [OCC_W-1:0]  tail;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              not_full;
  logic              issue_vld;
  logic              issue_fire;
  logic              accept;
  logic              cen;

  // A flush cycle ignores all inbound traffic and suppresses the handshake.
  assign not_full   = (occ_q != OCC_W'(DEPTH));
  assign cen        = rs.complete_en && !flash;
  assign issue_vld  = sel_found && !flash;
  assign issue_fire = issue_vld && rs.issue_ready;
  assign accept     = rs.in_valid && not_full && !flash;

  assign rs.in_ready       = not_full;
  assign rs.issue_valid    = issue_vld;
  assign rs.occupancy      = occ_q;
  assign rs.issue_op       = sel_found ? ent_q[sel_idx].op       : '0;
  assign rs.issue_a        = sel_found ? ent_q[sel_idx].data1    : '0;
  assign rs.issue_b        = sel_found ? ent_q[sel_idx].data2    : '0;
  assign rs.issue_dest_tag = sel_found ? ent_q[sel_idx].dest_tag : '0;

  // Oldest valid entry with both operands ready; scan from the top so the lowest index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((OCC_W'(i) < occ_q) && ent_q[i].rdy1 && ent_q[i].rdy2) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Broadcast wakeup applied to every stored operand still waiting on a matching tag.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (cen && !ent_q[i].rdy1 && (ent_q[i].tag1 == rs.complete_tag)) begin
        woke[i].rdy1  = 1'b1;
        woke[i].data1 = rs.complete_data;
      end
      if (cen && !ent_q[i].rdy2 && (ent_q[i].tag2 == rs.complete_tag)) begin
        woke[i].rdy2  = 1'b1;
        woke[i].data2 = rs.complete_data;
      end
    end
  end

  // Incoming entry, catching a completion that lands in the same cycle as dispatch.
  always_comb begin
    new_ent.op       = rs.in_op;
    new_ent.dest_tag = rs.in_dest_tag;
    new_ent.rdy1     = rs.src1_valid;
    new_ent.data1    = rs.src1_data;
    new_ent.tag1     = rs.src1_tag;
    new_ent.rdy2     = rs.src2_valid;
    new_ent.data2    = rs.src2_data;
    new_ent.tag2     = rs.src2_tag;
    if (!rs.src1_valid && cen && (rs.src1_tag == rs.complete_tag)) begin
      new_ent.rdy1  = 1'b1;
      new_ent.data1 = rs.complete_data;
    end
    if (!rs.src2_valid && cen && (rs.src2_tag == rs.complete_tag)) begin
      new_ent.rdy2  = 1'b1;
      new_ent.data2 = rs.complete_data;
    end
  end

  // Next state: collapse over the issued slot, then append the new entry at the post-issue tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = woke[i];
    end
    if (issue_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) begin
          ent_d[i] = woke[i + 1];
        end
      end
    end
    tail = occ_q - OCC_W'(issue_fire);
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (OCC_W'(i) == tail) begin
          ent_d[i] = new_ent;
        end
      end
    end
    occ_d = occ_q + OCC_W'(accept) - OCC_W'(issue_fire);
    if (flash) begin
      occ_d = '0;
    end
  end

  // Entry storage and occupancy; validity is implied by index < occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: vector table, directed corner sequences, then random traffic vs a queue model.
// Latency: checks outputs 1-2 time units after each rising edge, inputs applied just after the edge.
// Backpressure: issue_ready and in_valid are driven per cycle by the stimulus.
module tb_reservation_station;
  localparam int DEPTH  = 4;
  localparam int OP_W   = 8;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 64;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic flash   = 1'b0;
  int   tests   = 0;
  int   fails   = 0;

  always #5 clock = ~clock;

  reservation_station_if #(.DEPTH(DEPTH), .OP_W(OP_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) rs ();

  reservation_station #(.DEPTH(DEPTH), .OP_W(OP_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flash   (flash),
    .rs      (rs.slave)
  );

  typedef struct {
    logic              iv;
    logic [OP_W-1:0]   op;
    logic              s1v;
    logic [DATA_W-1:0] a;
    logic [TAG_W-1:0]  t1;
    logic              s2v;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  t2;
    logic              ce;
    logic [TAG_W-1:0]  ct;
    logic [DATA_W-1:0] cd;
    logic              ir;
    logic              e_iv;
    logic              e_rdy;
    int                e_occ;
    logic [OP_W-1:0]   e_op;
    logic [DATA_W-1:0] e_a;
    logic [DATA_W-1:0] e_b;
  } vec_t;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    logic              r1;
    logic [DATA_W-1:0] d1;
    logic [TAG_W-1:0]  t1;
    logic              r2;
    logic [DATA_W-1:0] d2;
    logic [TAG_W-1:0]  t2;
  } m_ent_t;

  vec_t   vecs[$];
  m_ent_t model[$];

  function automatic vec_t v(input int iv, input logic [OP_W-1:0] op,
                             input int s1v, input logic [DATA_W-1:0] a, input logic [TAG_W-1:0] t1,
                             input int s2v, input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] t2,
                             input int ce, input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cd,
                             input int ir, input int e_iv, input int e_rdy, input int e_occ,
                             input logic [OP_W-1:0] e_op, input logic [DATA_W-1:0] e_a,
                             input logic [DATA_W-1:0] e_b);
    vec_t r;
    r.iv = (iv != 0);   r.op = op;   r.s1v = (s1v != 0); r.a = a; r.t1 = t1;
    r.s2v = (s2v != 0); r.b = b;     r.t2 = t2;
    r.ce = (ce != 0);   r.ct = ct;   r.cd = cd;          r.ir = (ir != 0);
    r.e_iv = (e_iv != 0); r.e_rdy = (e_rdy != 0); r.e_occ = e_occ;
    r.e_op = e_op; r.e_a = e_a; r.e_b = e_b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rs.in_valid = 1'b0;  rs.in_op = '0;  rs.in_dest_tag = '0;
    rs.src1_valid = 1'b0; rs.src1_data = '0; rs.src1_tag = '0;
    rs.src2_valid = 1'b0; rs.src2_data = '0; rs.src2_tag = '0;
    rs.complete_en = 1'b0; rs.complete_tag = '0; rs.complete_data = '0;
    rs.issue_ready = 1'b0;
    flash = 1'b0;
  endtask

  task automatic put(input logic [OP_W-1:0] op, input int s1v, input logic [DATA_W-1:0] a,
                     input logic [TAG_W-1:0] t1, input int s2v, input logic [DATA_W-1:0] b,
                     input logic [TAG_W-1:0] t2);
    rs.in_valid = 1'b1; rs.in_op = op; rs.in_dest_tag = TAG_W'(op) + 64'h1000;
    rs.src1_valid = (s1v != 0); rs.src1_data = a; rs.src1_tag = t1;
    rs.src2_valid = (s2v != 0); rs.src2_data = b; rs.src2_tag = t2;
  endtask

  function automatic logic [TAG_W-1:0] rtag();
    return TAG_W'($urandom_range(1, 6)) | (TAG_W'($urandom_range(0, 1)) << 48);
  endfunction

  initial begin
    idle();
    #2;
    chk("reset_occupancy", rs.occupancy, 0);
    chk("reset_in_ready", rs.in_ready, 1);
    chk("reset_issue_valid", rs.issue_valid, 0);
    chk("reset_issue_a", rs.issue_a, 0);
    chk("reset_issue_op", rs.issue_op, 0);
    #10 reset_n = 1'b1;
    tick();

    // Cycle-by-cycle vectors: inputs this cycle, outputs expected in the same cycle.
    vecs.push_back(v(1, 8'h11, 1, 5, 0, 1, 7, 0,  0, 0, 0,  1,  0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,  1,  1, 1, 1, 8'h11, 5, 7));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,  1,  0, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 8'h22, 0, 0, 64'h2A, 1, 3, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,  1,  0, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      1, 64'h2A, 32'h100, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,  1,  1, 1, 1, 8'h22, 32'h100, 3));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,  1,  0, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 8'h33, 0, 0, 64'h9, 1, 4, 0, 1, 64'h9, 32'hBEEF, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,  0,  1, 1, 1, 8'h33, 32'hBEEF, 4));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,  1,  1, 1, 1, 8'h33, 32'hBEEF, 4));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,  1,  0, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 8'h44, 0, 0, 64'h5, 0, 0, 64'h6, 1, 64'h7, 1, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      1, 64'h6, 32'h66, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      1, 64'h5, 32'h55, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,  1,  1, 1, 1, 8'h44, 32'h55, 32'h66));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,  1,  0, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 8'h55, 0, 0, 64'hABCDEF0123456789, 0, 0, 64'hABCDEF0123456789,
                     0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      1, 64'h2BCDEF0123456789, 1, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      1, 64'hABCDEF0123456789, 32'h77, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,  1,  1, 1, 1, 8'h55, 32'h77, 32'h77));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,  1,  0, 1, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      rs.in_valid = vecs[k].iv; rs.in_op = vecs[k].op; rs.in_dest_tag = '0;
      rs.src1_valid = vecs[k].s1v; rs.src1_data = vecs[k].a; rs.src1_tag = vecs[k].t1;
      rs.src2_valid = vecs[k].s2v; rs.src2_data = vecs[k].b; rs.src2_tag = vecs[k].t2;
      rs.complete_en = vecs[k].ce; rs.complete_tag = vecs[k].ct; rs.complete_data = vecs[k].cd;
      rs.issue_ready = vecs[k].ir;
      #1;
      chk($sformatf("vec%0d_issue_valid", k), rs.issue_valid, vecs[k].e_iv);
      chk($sformatf("vec%0d_in_ready", k), rs.in_ready, vecs[k].e_rdy);
      chk($sformatf("vec%0d_occupancy", k), rs.occupancy, 64'(vecs[k].e_occ));
      if (vecs[k].e_iv) begin
        chk($sformatf("vec%0d_issue_op", k), rs.issue_op, vecs[k].e_op);
        chk($sformatf("vec%0d_issue_a", k), rs.issue_a, vecs[k].e_a);
        chk($sformatf("vec%0d_issue_b", k), rs.issue_b, vecs[k].e_b);
      end
      tick();
    end

    // Full queue with a blocked oldest entry: younger ready entries bypass it in age order.
    idle(); put(8'h40, 0, 0, 64'h1, 1, 2, 0); tick();
    for (int i = 1; i < 4; i++) begin
      idle(); put(OP_W'(8'h40 + i), 1, DATA_W'(8'h40 + i), 0, 1, DATA_W'(i), 0); tick();
    end
    idle(); #1;
    chk("p4_full_occupancy", rs.occupancy, 4);
    chk("p4_full_in_ready", rs.in_ready, 0);
    rs.issue_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("p4_issue_valid", rs.issue_valid, 1);
      chk("p4_issue_order", rs.issue_op, OP_W'(8'h40 + i));
      if (i == 1) chk("p4_no_same_cycle_credit", rs.in_ready, 0);
      if (i == 2) begin
        chk("p4_credit_after_issue", rs.in_ready, 1);
        chk("p4_occupancy_3", rs.occupancy, 3);
      end
      tick();
    end
    #1;
    chk("p4_blocked_no_issue", rs.issue_valid, 0);
    chk("p4_blocked_occupancy", rs.occupancy, 1);
    rs.complete_en = 1'b1; rs.complete_tag = 64'h1; rs.complete_data = 32'h9; #1;
    chk("p4_wake_not_same_cycle", rs.issue_valid, 0);
    tick(); idle(); rs.issue_ready = 1'b1; #1;
    chk("p4_woken_issue_valid", rs.issue_valid, 1);
    chk("p4_woken_op", rs.issue_op, 8'h40);
    chk("p4_woken_a", rs.issue_a, 32'h9);
    chk("p4_woken_b", rs.issue_b, 32'h2);
    tick(); idle(); #1;
    chk("p4_drained", rs.occupancy, 0);

    // Full queue: offered op waits for the issue, then lands; accept+issue when not full keeps occupancy.
    for (int i = 0; i < 4; i++) begin
      idle(); put(OP_W'(8'h50 + i), 1, DATA_W'(i), 0, 1, DATA_W'(i), 0); tick();
    end
    idle(); put(8'h54, 1, 4, 0, 1, 4, 0); rs.issue_ready = 1'b1; #1;
    chk("p5_full_in_ready", rs.in_ready, 0);
    chk("p5_issue_op", rs.issue_op, 8'h50);
    tick(); rs.issue_ready = 1'b0; #1;
    chk("p5_after_issue_occ", rs.occupancy, 3);
    chk("p5_after_issue_in_ready", rs.in_ready, 1);
    tick(); idle(); #1;
    chk("p5_accepted_occ", rs.occupancy, 4);
    rs.issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) put(8'h55, 1, 5, 0, 1, 5, 0);
      else rs.in_valid = 1'b0;
      #1;
      chk("p5_drain_order", rs.issue_op, OP_W'(8'h51 + i));
      if (i == 2) chk("p5_accept_plus_issue_occ", rs.occupancy, 3);
      tick();
    end
    idle(); #1;
    chk("p5_drained", rs.occupancy, 0);

    // Flush with traffic on every input, then an asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) begin
      idle(); put(OP_W'(8'h60 + i), 1, 1, 0, 1, 1, 0); tick();
    end
    idle(); put(8'h70, 1, 1, 0, 1, 1, 0);
    rs.complete_en = 1'b1; rs.issue_ready = 1'b1; flash = 1'b1; #1;
    chk("p6_flush_forces_no_issue", rs.issue_valid, 0);
    tick(); idle(); #1;
    chk("p6_flush_occupancy", rs.occupancy, 0);
    chk("p6_flush_issue_valid", rs.issue_valid, 0);
    chk("p6_flush_in_ready", rs.in_ready, 1);
    for (int i = 0; i < 2; i++) begin
      idle(); put(OP_W'(8'h80 + i), 1, 1, 0, 1, 1, 0); tick();
    end
    idle(); #1;
    chk("p6_pre_reset_occ", rs.occupancy, 2);
    reset_n = 1'b0; #1;
    chk("p6_async_reset_occ", rs.occupancy, 0);
    chk("p6_async_reset_issue_valid", rs.issue_valid, 0);
    #1 reset_n = 1'b1;
    tick(); #1;
    chk("p6_post_reset_empty", rs.occupancy, 0);
    put(8'h90, 1, 32'hA, 0, 1, 32'hB, 0); tick(); idle(); #1;
    chk("p6_post_reset_issue", rs.issue_op, 8'h90);
    rs.issue_ready = 1'b1; tick(); idle(); #1;
    chk("p6_post_reset_drained", rs.occupancy, 0);

    // Random traffic against a queue model kept in age order.
    model.delete();
    for (int c = 0; c < 800; c++) begin
      int     sel;
      logic   exp_iv;
      logic   acc;
      m_ent_t n;
      rs.in_valid = ($urandom_range(0, 9) < 6);
      rs.in_op = OP_W'($urandom); rs.in_dest_tag = {$urandom, $urandom};
      rs.src1_valid = $urandom_range(0, 1) == 1; rs.src1_data = $urandom; rs.src1_tag = rtag();
      rs.src2_valid = $urandom_range(0, 1) == 1; rs.src2_data = $urandom; rs.src2_tag = rtag();
      rs.complete_en = ($urandom_range(0, 9) < 4);
      rs.complete_tag = rtag(); rs.complete_data = $urandom;
      rs.issue_ready = ($urandom_range(0, 9) < 6);
      flash = ($urandom_range(0, 59) == 0);
      #1;
      sel = -1;
      for (int k = 0; k < model.size(); k++)
        if (sel < 0 && model[k].r1 && model[k].r2) sel = k;
      exp_iv = (sel >= 0) && !flash;
      chk("rnd_occupancy", rs.occupancy, 64'(model.size()));
      chk("rnd_in_ready", rs.in_ready, model.size() < DEPTH);
      chk("rnd_issue_valid", rs.issue_valid, exp_iv);
      if (exp_iv) begin
        chk("rnd_issue_op", rs.issue_op, model[sel].op);
        chk("rnd_issue_a", rs.issue_a, model[sel].d1);
        chk("rnd_issue_b", rs.issue_b, model[sel].d2);
        chk("rnd_issue_dest", rs.issue_dest_tag, model[sel].dest);
      end
      if (flash) begin
        model.delete();
      end else begin
        acc = rs.in_valid && (model.size() < DEPTH);
        if (rs.complete_en) begin
          for (int k = 0; k < model.size(); k++) begin
            if (!model[k].r1 && model[k].t1 == rs.complete_tag) begin
              model[k].r1 = 1'b1; model[k].d1 = rs.complete_data;
            end
            if (!model[k].r2 && model[k].t2 == rs.complete_tag) begin
              model[k].r2 = 1'b1; model[k].d2 = rs.complete_data;
            end
          end
        end
        if (exp_iv && rs.issue_ready) model.delete(sel);
        if (acc) begin
          n.op = rs.in_op; n.dest = rs.in_dest_tag;
          n.r1 = rs.src1_valid; n.d1 = rs.src1_data; n.t1 = rs.src1_tag;
          n.r2 = rs.src2_valid; n.d2 = rs.src2_data; n.t2 = rs.src2_tag;
          if (!n.r1 && rs.complete_en && n.t1 == rs.complete_tag) begin
            n.r1 = 1'b1; n.d1 = rs.complete_data;
          end
          if (!n.r2 && rs.complete_en && n.t2 == rs.complete_tag) begin
            n.r2 = 1'b1; n.d2 = rs.complete_data;
          end
          model.push_back(n);
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Issue queue between the rename/register-read stage and the ALU.
- Captures each renamed instruction together with the two source operands the register file returns. An operand arrives either as a value or as a pending 64-bit physical tag.
- Snoops the completion broadcast to wake up pending operands.
- Issues the oldest fully-ready entry to the execution unit under a valid/ready handshake.

Parameters:
DEPTH, 4, number of entries (≥2)
OP_W, 8, opcode/control field width
DATA_W, 32, operand data width
TAG_W, 64, physical tag width (matches register-file tag generator)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
flash  in  1  synchronous pipeline flush
in_valid  in  1  instruction offered
in_ready  out  1  station can accept (not full)
in_op  in  OP_W  opcode
in_dest_tag  in  TAG_W  destination physical tag
src1_valid  in  1  1: src1_data holds value; 0: src1_tag pending
src1_data  in  DATA_W  operand 1 value
src1_tag  in  TAG_W  operand 1 pending tag
src2_valid  in  1  as src1
src2_data  in  DATA_W  operand 2 value
src2_tag  in  TAG_W  operand 2 pending tag
complete_en  in  1  completion broadcast valid
complete_tag  in  TAG_W  tag of completed result
complete_data  in  DATA_W  completed value
issue_valid  out  1  oldest ready entry presented
issue_ready  in  1  execution unit accepts
issue_op  out  OP_W  opcode of issued entry
issue_a  out  DATA_W  operand 1
issue_b  out  DATA_W  operand 2
issue_dest_tag  out  TAG_W  destination tag
occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- Storage: DEPTH entries held in age order. Index 0 is the oldest; valid entries are contiguous from 0. Each entry holds op, dest_tag, and per operand {rdy, data, tag}.
- Reset (reset_n=0, async): all entries invalid, occupancy=0, issue_valid=0, in_ready=1. Issue data outputs are don't-care but drive 0.
- in_ready = (occupancy != DEPTH). It is combinational from registered occupancy; a same-cycle issue gives no credit. in_ready does not depend on in_valid.
- Accept: in_valid && in_ready → entry written at tail. The tail is occupancy, minus 1 if an issue fires in the same cycle.
- Accept-time snoop: an incoming operand with srcN_valid=0, complete_en=1 and complete_tag==srcN_tag is stored rdy=1 with complete_data.
- Wakeup: each cycle with complete_en, every valid entry operand with rdy=0 and tag==complete_tag is set rdy=1, data=complete_data, at the next edge. Multiple entries and both operands of one entry may wake together.
- Select (combinational): lowest-index valid entry with both rdy=1. issue_valid=1 if one exists; issue_* driven from it.
- Issue: issue_valid && issue_ready → the selected entry is removed at the edge. Entries above it shift down one index, applying any same-cycle wakeup during the shift. Age order is preserved.
- issue_valid may rise and fall without handshake. The selected entry changes only through state updates, never mid-cycle.
- Latency: an instruction accepted with both operands ready (or woken at accept) gives issue_valid=1 the following cycle. An operand woken by broadcast in cycle N becomes issuable in cycle N+1.
- Simultaneous accept+issue when full: accept blocked (in_ready=0); the issue proceeds; occupancy becomes DEPTH-1.
- Simultaneous accept+issue not full: both occur; occupancy unchanged.
- flash=1: all entries invalidated at the edge, occupancy=0. In that cycle in_valid, complete_en and issue_ready are ignored and no handshake is counted; issue_valid is forced 0.
- Tag comparison is full TAG_W equality. Tags are unique, so at most one producer matches.
- Reset asserted mid-operation clears immediately regardless of clock; the first edge after deassertion behaves as empty.

Test Plan:
1. Reset, then accept op=0x11, both valid, a=5, b=7, issue_ready=1 → next cycle issue_valid=1, issue_a=5, issue_b=7; following cycle occupancy=0.
2. Accept op with src1 pending tag=0x2A, src2 valid 3; two cycles later complete_en, tag=0x2A, data=0x100 → issue_valid=1 the cycle after, issue_a=0x100, issue_b=3.
3. Accept with src1 tag=0x9 while complete_en tag=0x9 data=0xBEEF same cycle → stored ready; issue_valid next cycle, issue_a=0xBEEF.
4. Fill 4 entries (entry0 pending tag 1, entries1-3 ready), issue_ready=1 → entries 1,2,3 issue in age order; in_ready 0 while full, 1 after the first issue.
5. Full queue, in_valid=1, issue fires → no accept; occupancy 4→3; next cycle the instruction is accepted.
6. Three entries resident, pulse flash with complete_en and in_valid high → occupancy=0, issue_valid=0 next cycle, nothing accepted. Mid-run async reset_n low → occupancy 0 before the next edge.
